// File: rtl/uart_rx_bit_timer.sv
// rtl/uart_rx_bit_timer.sv - UART receive bit timer: start-bit qualification and mid-bit sample strobes
module uart_rx_bit_timer #(
  parameter int DIV_W     = 16,
  parameter int RESET_DIV = 5208,
  parameter int DATA_BITS = 8,
  parameter int PARITY_EN = 0,
  parameter int STOP_BITS = 1
) (
  input  logic             clk_50M,
  input  logic             reset,
  input  logic             enable,
  input  logic             rx_in,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  output logic [DIV_W-1:0] baud_div,
  output logic             sample,
  output logic [3:0]       bit_idx,
  output logic [1:0]       bit_kind,
  output logic             busy,
  output logic             frame_done,
  output logic             frame_err,
  output logic             false_start
);

  localparam int NBITS = 1 + DATA_BITS + PARITY_EN + STOP_BITS;
  localparam logic [3:0] LAST_IDX = 4'(NBITS - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS);
  localparam logic [3:0] PAR_IDX = 4'(DATA_BITS + 1);
  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO = DIV_W'(2);
  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(RESET_DIV);

  if (RESET_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY_EN < 0 || PARITY_EN > 1 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_err
    $error("uart_rx_bit_timer: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, START_CHK, RUN} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             rx_q;
  logic [3:0]       idx_q, idx_d;
  logic [1:0]       kind_q, kind_d;
  logic             sample_q, sample_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             fs_q, fs_d;
  logic             stop_err_q, stop_err_d;

  logic             edge_fall;
  logic [DIV_W-1:0] half_m1;
  logic [3:0]       next_idx;
  logic [1:0]       next_kind;
  logic             stop_low;

  function automatic logic [1:0] kind_of(input logic [3:0] idx);
    if (idx == 4'd0) return 2'd0;
    else if (idx <= DATA_LAST) return 2'd1;
    else if (PARITY_EN != 0 && idx == PAR_IDX) return 2'd2;
    else return 2'd3;
  endfunction

  always_comb begin
    edge_fall  = rx_q & ~rx_in;
    half_m1    = (div_q >> 1) - ONE;
    next_idx   = idx_q + 4'd1;
    next_kind  = kind_of(next_idx);
    stop_low   = (next_kind == 2'd3) && !rx_in;

    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    idx_d      = idx_q;
    kind_d     = kind_q;
    stop_err_d = stop_err_q;
    sample_d   = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    fs_d       = 1'b0;

    case (state_q)
      IDLE: begin
        idx_d      = 4'd0;
        cnt_d      = '0;
        stop_err_d = 1'b0;
        if (div_load) div_d = (div_value < TWO) ? TWO : div_value;
        if (enable && edge_fall) state_d = START_CHK;
      end
      START_CHK: begin
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == half_m1) begin
          cnt_d = '0;
          if (!rx_in) begin
            sample_d = 1'b1;
            idx_d    = 4'd0;
            kind_d   = 2'd0;
            state_d  = RUN;
          end else begin
            fs_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = 4'd0;
        end else if (cnt_q == div_q - ONE) begin
          cnt_d    = '0;
          sample_d = 1'b1;
          idx_d    = next_idx;
          kind_d   = next_kind;
          // Last stop bit closes the frame; the edge detector is live again next cycle.
          if (next_idx == LAST_IDX) begin
            done_d  = 1'b1;
            err_d   = stop_err_q | stop_low;
            state_d = IDLE;
          end else begin
            stop_err_d = stop_err_q | stop_low;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= RST_DIV;
      rx_q       <= 1'b1;
      idx_q      <= 4'd0;
      kind_q     <= 2'd0;
      stop_err_q <= 1'b0;
      sample_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      fs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      rx_q       <= rx_in;
      idx_q      <= idx_d;
      kind_q     <= kind_d;
      stop_err_q <= stop_err_d;
      sample_q   <= sample_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      fs_q       <= fs_d;
    end
  end

  assign baud_div    = div_q;
  assign sample      = sample_q;
  assign bit_idx     = idx_q;
  assign bit_kind    = kind_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign frame_err   = err_q;
  assign false_start = fs_q;

endmodule
